iddr_pattern_checker: RTL and testbench
=======================================

// Module: iddr_pattern_checker
// PURPOSE
//  Receive side of the ODDR output tests: captures a single-ended DDR input lane with
//  an IDDR primitive, rebuilds {rise,fall} bit pairs and checks them against a known
//  constant pair (e.g. D1=1/D2=0 from the ODDR transmitter, looped back on the board).
//  Reports lock, bit-pair swap (half-cycle misalignment) and a saturating error count
//  for LEDs / the test harness.
// PARAMETERS
//  EXP_RISE    1'b1  expected bit captured on the rising edge
//  EXP_FALL    1'b0  expected bit captured on the falling edge
//  LOCK_LEN    16    consecutive good pairs needed to declare lock (>=2)
//  UNLOCK_LEN  4     consecutive bad pairs in LOCKED that drop lock (>=1)
//  ERR_W       16    width of err_count
// PORTS
//  clk         in   1      capture clock (same clock that drives the ODDR under test)
//  rst_n       in   1      async active-low reset
//  ddr_in      in   1      DDR data lane from the pin
//  clear       in   1      sync clear of err_count and lost
//  rx_pair     out  2      registered {rise,fall} pair
//  locked      out  1      1 while FSM in LOCKED
//  swapped     out  1      lock obtained on {EXP_FALL,EXP_RISE} orientation
//  lost        out  1      sticky: lock was lost at least once since reset/clear
//  err_count   out  ERR_W  saturating count of bad pairs while LOCKED
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low. All outputs 0, FSM=SEARCH,
//   counters 0. IDDR R driven by ~rst_n.
//  Capture: IDDR DDR_CLK_EDGE="SAME_EDGE_PIPELINED", INIT_Q1/Q2=0, SRTYPE="ASYNC";
//   {Q1,Q2} registered into rx_pair -> rx_pair valid 2 clk after the rising-edge sample.
//  Classify rx_pair each cycle: MATCH={EXP_RISE,EXP_FALL}; SWAP={EXP_FALL,EXP_RISE}
//   (only when EXP_RISE!=EXP_FALL, else SWAP never asserted); GOOD = matches latched
//   orientation (swp ? SWAP : MATCH); else BAD.
//  FSM:
//   SEARCH: MATCH -> VERIFY, swp=0, run=1; SWAP -> VERIFY, swp=1, run=1; else stay.
//   VERIFY: GOOD -> run++, when run reaches LOCK_LEN -> LOCKED; BAD -> SEARCH, run=0.
//   LOCKED: GOOD -> miss=0; BAD -> miss++, err_count++ (saturate at all-ones);
//           miss reaching UNLOCK_LEN -> LOST.
//   LOST:   single cycle; set lost=1, miss=0, run=0 -> SEARCH.
//  locked is registered: high the cycle after the LOCK_LEN-th consecutive GOOD pair;
//   low the cycle after the UNLOCK_LEN-th consecutive BAD pair.
//  swapped = swp while in LOCKED, 0 otherwise.
//  clear: sync; zeros err_count and lost. Clear wins over a same-cycle increment or a
//   same-cycle LOST entry (lost stays 0). Does not affect FSM or locked.
//  run/miss counters sized $clog2(LOCK_LEN+1)/$clog2(UNLOCK_LEN+1); never wrap.
//  rst_n low mid-lock: immediate return to reset state, no lost flag.
// STRUCTURE
//  Package iddr_test_pkg: state enum {SEARCH,VERIFY,LOCKED,LOST}, pair classification
//   constants, saturating-increment function shared with other iologic checkers.
//  One sub-module: iddr_capture (IDDR instance + output pair register), so the checker
//   FSM can be simulated with the primitive swapped for a behavioural model.
// TESTING
//  1 Reset, then drive 1 on rising / 0 on falling for 20 clk -> locked=1 exactly
//    LOCK_LEN+2 clk after first valid pair, swapped=0, err_count=0.
//  2 Drive 0 rise / 1 fall -> locks with swapped=1; rx_pair=2'b01.
//  3 Locked, inject 3 bad pairs then good -> err_count=3, locked stays 1, lost=0.
//  4 Locked, inject UNLOCK_LEN=4 bad pairs -> locked=0 next cycle, lost=1, err_count=4,
//    then re-locks after LOCK_LEN good pairs.
//  5 err_count preloaded to near max via ERR_W=2: 5 isolated errors -> holds at 3;
//    clear asserted with an error same cycle -> err_count=0.
//  6 Pull rst_n low mid-VERIFY (async, between edges) -> all outputs 0 immediately.

Source files
------------

// File: rtl/iddr_test_pkg.sv
// Shared types and helpers for the iologic loopback checkers.
// Holds the pair classifier, the checker state encoding and a saturating increment.
package iddr_test_pkg;

   typedef enum logic [1:0] {
      SEARCH,
      VERIFY,
      LOCKED,
      LOST
   } chk_state_t;

   typedef enum logic [1:0] {
      PAIR_BAD,
      PAIR_MATCH,
      PAIR_SWAP
   } pair_class_t;

   localparam int PAIR_W = 2;

   // SWAP only exists when the two expected bits differ; otherwise it aliases MATCH.
   function automatic pair_class_t classify_pair(input logic [PAIR_W-1:0] pair,
                                                 input logic              exp_rise,
                                                 input logic              exp_fall);
      if (pair == {exp_rise, exp_fall})
         return PAIR_MATCH;
      if ((exp_rise != exp_fall) && (pair == {exp_fall, exp_rise}))
         return PAIR_SWAP;
      return PAIR_BAD;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max_value);
      return (value >= max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/iddr_capture.sv
// DDR capture of one input lane: behavioural equivalent of an IDDR in
// SAME_EDGE_PIPELINED mode with async R, followed by the output pair register.
module iddr_capture
   import iddr_test_pkg::*;
#(
   parameter logic INIT_Q1 = 1'b0,
   parameter logic INIT_Q2 = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ddr_in,
   output logic [PAIR_W-1:0] rx_pair
);

   logic iddr_r;
   logic rise_reg;
   logic fall_reg;
   logic q1_reg;
   logic q2_reg;

   assign iddr_r = ~rst_n;

   // Rising sample is held one extra cycle so Q1 and Q2 leave on the same edge.
   always_ff @(posedge clk or posedge iddr_r) begin
      if (iddr_r) begin
         rise_reg <= INIT_Q1;
         q1_reg   <= INIT_Q1;
         q2_reg   <= INIT_Q2;
      end else begin
         rise_reg <= ddr_in;
         q1_reg   <= rise_reg;
         q2_reg   <= fall_reg;
      end
   end

   always_ff @(negedge clk or posedge iddr_r) begin
      if (iddr_r)
         fall_reg <= INIT_Q2;
      else
         fall_reg <= ddr_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rx_pair <= '0;
      else
         rx_pair <= {q1_reg, q2_reg};
   end

endmodule

// File: rtl/iddr_pattern_checker.sv
// Loopback checker for a constant DDR bit pair: finds lock in either orientation,
// tracks loss of lock and counts bad pairs while locked.
module iddr_pattern_checker
   import iddr_test_pkg::*;
#(
   parameter logic EXP_RISE   = 1'b1,
   parameter logic EXP_FALL   = 1'b0,
   parameter int   LOCK_LEN   = 16,
   parameter int   UNLOCK_LEN = 4,
   parameter int   ERR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ddr_in,
   input  logic              clear,
   output logic [PAIR_W-1:0] rx_pair,
   output logic              locked,
   output logic              swapped,
   output logic              lost,
   output logic [ERR_W-1:0]  err_count
);

   localparam int RUN_W  = $clog2(LOCK_LEN + 1);
   localparam int MISS_W = $clog2(UNLOCK_LEN + 1);
   localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_LEN);
   localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(UNLOCK_LEN);
   localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

   chk_state_t        state_reg;
   logic              swp_reg;
   logic [RUN_W-1:0]  run_reg;
   logic [MISS_W-1:0] miss_reg;
   logic              locked_reg;
   logic              lost_reg;
   logic [ERR_W-1:0]  err_reg;

   pair_class_t       pair_class;
   logic              pair_good;
   logic [RUN_W-1:0]  run_inc;
   logic [MISS_W-1:0] miss_inc;

   iddr_capture u_capture (
      .clk     (clk),
      .rst_n   (rst_n),
      .ddr_in  (ddr_in),
      .rx_pair (rx_pair)
   );

   always_comb begin
      pair_class = classify_pair(rx_pair, EXP_RISE, EXP_FALL);
      pair_good  = swp_reg ? (pair_class == PAIR_SWAP) : (pair_class == PAIR_MATCH);
      run_inc    = run_reg + 1'b1;
      miss_inc   = miss_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= SEARCH;
         swp_reg    <= 1'b0;
         run_reg    <= '0;
         miss_reg   <= '0;
         locked_reg <= 1'b0;
         lost_reg   <= 1'b0;
         err_reg    <= '0;
      end else begin
         case (state_reg)
            SEARCH: begin
               if (pair_class != PAIR_BAD) begin
                  state_reg <= VERIFY;
                  swp_reg   <= (pair_class == PAIR_SWAP);
                  run_reg   <= RUN_W'(1);
               end
            end
            VERIFY: begin
               if (pair_good) begin
                  run_reg <= run_inc;
                  if (run_inc == RUN_LOCK) begin
                     state_reg  <= LOCKED;
                     locked_reg <= 1'b1;
                     miss_reg   <= '0;
                  end
               end else begin
                  state_reg <= SEARCH;
                  run_reg   <= '0;
               end
            end
            LOCKED: begin
               if (pair_good) begin
                  miss_reg <= '0;
               end else begin
                  miss_reg <= miss_inc;
                  err_reg  <= ERR_W'(sat_inc(32'(err_reg), 32'(ERR_MAX)));
                  if (miss_inc == MISS_DROP) begin
                     state_reg  <= LOST;
                     locked_reg <= 1'b0;
                     lost_reg   <= 1'b1;
                  end
               end
            end
            LOST: begin
               state_reg <= SEARCH;
               miss_reg  <= '0;
               run_reg   <= '0;
            end
            default: state_reg <= SEARCH;
         endcase
         // Placed after the case so it overrides a same-cycle count or loss event.
         if (clear) begin
            err_reg  <= '0;
            lost_reg <= 1'b0;
         end
      end
   end

   assign locked    = locked_reg;
   assign swapped   = locked_reg & swp_reg;
   assign lost      = lost_reg;
   assign err_count = err_reg;

endmodule

// File: tb/tb_iddr_pattern_checker.sv
// Randomised loopback bench for iddr_pattern_checker with a queue-based scoreboard
// fed by a pair-stream reference model.
module tb_iddr_pattern_checker;

   localparam logic EXP_RISE   = 1'b1;
   localparam logic EXP_FALL   = 1'b0;
   localparam int   LOCK_LEN   = 16;
   localparam int   UNLOCK_LEN = 4;
   localparam int   ERR_W      = 2;
   localparam int   ERR_MAX    = (1 << ERR_W) - 1;
   localparam logic [1:0] MATCH = {EXP_RISE, EXP_FALL};
   localparam logic [1:0] SWAP  = {EXP_FALL, EXP_RISE};

   logic             clk;
   logic             rst_n;
   logic             ddr_in;
   logic             clear;
   logic [1:0]       rx_pair;
   logic             locked;
   logic             swapped;
   logic             lost;
   logic [ERR_W-1:0] err_count;

   iddr_pattern_checker #(
      .EXP_RISE   (EXP_RISE),
      .EXP_FALL   (EXP_FALL),
      .LOCK_LEN   (LOCK_LEN),
      .UNLOCK_LEN (UNLOCK_LEN),
      .ERR_W      (ERR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ddr_in    (ddr_in),
      .clear     (clear),
      .rx_pair   (rx_pair),
      .locked    (locked),
      .swapped   (swapped),
      .lost      (lost),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  rx;
      logic        lk;
      logic        sw;
      logic        lo;
      logic [31:0] err;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [1:0] hist[$];
   bit         check_en;
   int         n_checks;
   int         n_fail;

   // Reference model state: lock status, orientation, good streak, miss streak.
   bit m_locked, m_swp, m_lost, m_gap;
   int m_streak, m_miss, m_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [1:0] target(input bit swp);
      return swp ? SWAP : MATCH;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_swp = 0; m_lost = 0; m_gap = 0;
      m_streak = 0; m_miss = 0; m_err = 0;
   endtask

   task automatic model_step(input logic [1:0] p, input bit clr);
      bit drop;
      drop = 0;
      if (m_gap) begin
         m_gap    = 0;
         m_streak = 0;
      end else if (!m_locked) begin
         if (m_streak == 0) begin
            if (p == MATCH) begin
               m_swp = 0; m_streak = 1;
            end else if (p == SWAP && EXP_RISE != EXP_FALL) begin
               m_swp = 1; m_streak = 1;
            end
         end else if (p == target(m_swp)) begin
            m_streak++;
            if (m_streak == LOCK_LEN) begin
               m_locked = 1; m_miss = 0;
            end
         end else begin
            m_streak = 0;
         end
      end else begin
         if (p == target(m_swp)) begin
            m_miss = 0;
         end else begin
            m_miss++;
            if (m_err < ERR_MAX) m_err++;
            if (m_miss == UNLOCK_LEN) begin
               m_locked = 0; m_gap = 1; m_miss = 0; m_streak = 0; drop = 1;
            end
         end
      end
      if (clr) begin
         m_err = 0; m_lost = 0;
      end else if (drop) begin
         m_lost = 1;
      end
   endtask

   // Called at negedge+1; drives one {rise,fall} pair and queues what the DUT shows after the next edge.
   task automatic step(input logic [1:0] p, input bit clr);
      exp_t e;
      hist.push_back(p);
      model_step(hist[0], clr);
      e.rx  = hist[1];
      e.lk  = m_locked;
      e.sw  = m_locked & m_swp;
      e.lo  = m_lost;
      e.err = 32'(m_err);
      exp_q.push_back(e);
      void'(hist.pop_front());
      ddr_in = p[1];
      clear  = clr;
      @(posedge clk);
      #2 ddr_in = p[0];
      @(negedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rx_pair"},   32'(rx_pair),   32'd0);
      chk({tag, "_locked"},    32'(locked),    32'd0);
      chk({tag, "_swapped"},   32'(swapped),   32'd0);
      chk({tag, "_lost"},      32'(lost),      32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   task automatic do_reset();
      check_en = 0;
      rst_n    = 1'b0;
      ddr_in   = 1'b0;
      clear    = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk);
      #1;
      model_reset();
      exp_q.delete();
      hist.delete();
      repeat (3) hist.push_back(2'b00);
      rst_n    = 1'b1;
      check_en = 1;
   endtask

   // Called at negedge+1: drops rst_n between edges and expects outputs to clear at once.
   task automatic async_reset_check(input string tag);
      check_en = 0;
      #2 rst_n = 1'b0;
      #1 check_all_zero(tag);
   endtask

   always @(posedge clk) begin
      if (check_en) begin
         #1;
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rx_pair",   32'(rx_pair),   32'(mon_e.rx));
            chk("locked",    32'(locked),    32'(mon_e.lk));
            chk("swapped",   32'(swapped),   32'(mon_e.sw));
            chk("lost",      32'(lost),      32'(mon_e.lo));
            chk("err_count", 32'(err_count), mon_e.err);
         end
      end
   end

   logic [1:0] r_base;
   logic [1:0] r_pair;
   bit         r_clr;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      check_en = 0;
      rst_n    = 1'b0;
      ddr_in   = 1'b0;
      clear    = 1'b0;

      do_reset();
      // Straight lock on the expected orientation, then isolated errors.
      repeat (22) step(MATCH, 0);
      repeat (3) step(2'b00, 0);
      repeat (5) step(MATCH, 0);
      // Lose lock with UNLOCK_LEN bad pairs, then relock.
      repeat (UNLOCK_LEN) step(2'b11, 0);
      repeat (22) step(MATCH, 0);
      // Saturating error count, then clear colliding with an error.
      repeat (5) begin
         step(2'b00, 0); step(MATCH, 0); step(MATCH, 0);
      end
      step(2'b01, 0); step(MATCH, 0); step(MATCH, 0); step(MATCH, 1);
      repeat (3) step(MATCH, 0);
      // Clear landing on the same cycle as the loss of lock.
      repeat (UNLOCK_LEN) step(2'b00, 0);
      step(MATCH, 0); step(MATCH, 0); step(MATCH, 1);
      repeat (4) step(MATCH, 0);
      // Swapped orientation lock.
      repeat (30) step(SWAP, 0);
      repeat (2) step(2'b11, 0);
      repeat (6) step(SWAP, 0);

      // Randomised blocks of one orientation with sprinkled bad pairs and clears.
      for (int blk = 0; blk < 12; blk++) begin
         r_base = ($urandom_range(0, 2) == 0) ? SWAP : MATCH;
         for (int i = 0; i < 60; i++) begin
            r_pair = r_base;
            if ($urandom_range(0, 99) < 10)
               r_pair = r_base ^ 2'($urandom_range(1, 3));
            r_clr = ($urandom_range(0, 99) < 4);
            step(r_pair, r_clr);
         end
      end

      // Asynchronous reset while locked with errors counted, then mid-verify.
      do_reset();
      repeat (22) step(MATCH, 0);
      repeat (2) step(2'b00, 0);
      repeat (4) step(MATCH, 0);
      async_reset_check("async_mid_lock");
      do_reset();
      repeat (12) step(MATCH, 0);
      async_reset_check("async_mid_verify");
      do_reset();
      repeat (8) step(MATCH, 0);

      check_en = 0;
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
